// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
// Package     : elevator_pkg
// Description : Shared state/direction enums and default parameters.
// Revision    : 1.0 - initial release
// ============================================================================
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

    localparam int c_DEFAULT_FLOOR_W       = 16;
    localparam int c_DEFAULT_NUM_FLOORS    = 16;
    localparam int c_DEFAULT_TRAVEL_CYCLES = 2;
    localparam int c_DEFAULT_DWELL_CYCLES  = 3;

endpackage
`default_nettype wire

// File: rtl/scan_target_sel.sv
`default_nettype none
// ============================================================================
// Module      : scan_target_sel
// Description : Finds pending floors ahead/behind the car and the nearest one ahead.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_target_sel
    import elevator_pkg::*;
#(
    parameter int FLOOR_W    = c_DEFAULT_FLOOR_W,
    parameter int NUM_FLOORS = c_DEFAULT_NUM_FLOORS
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  dir_t                  dir,
    output logic                  ahead_any,
    output logic                  behind_any,
    output logic [FLOOR_W-1:0]    nearest_ahead
);

    logic [31:0]        w_cur;
    logic               w_above_any;
    logic               w_below_any;
    logic [FLOOR_W-1:0] w_lowest_above;
    logic [FLOOR_W-1:0] w_highest_below;

    assign w_cur = 32'(current_floor);

    // Descending scan leaves the lowest floor above; ascending leaves the highest below.
    always_comb begin
        w_above_any     = 1'b0;
        w_below_any     = 1'b0;
        w_lowest_above  = '0;
        w_highest_below = '0;
        for (int k = NUM_FLOORS - 1; k >= 0; k--) begin
            if (pending[k] && (32'(k) > w_cur)) begin
                w_above_any    = 1'b1;
                w_lowest_above = FLOOR_W'(k);
            end
        end
        for (int k = 0; k < NUM_FLOORS; k++) begin
            if (pending[k] && (32'(k) < w_cur)) begin
                w_below_any     = 1'b1;
                w_highest_below = FLOOR_W'(k);
            end
        end
    end

    assign ahead_any     = (dir == UP) ? w_above_any : w_below_any;
    assign behind_any    = (dir == UP) ? w_below_any : w_above_any;
    assign nearest_ahead = (dir == UP) ? w_lowest_above : w_highest_below;

endmodule
`default_nettype wire

// File: rtl/elevator_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : elevator_scan_scheduler
// Description : SCAN elevator scheduler: request bitmap, IDLE/MOVE/DOOR FSM, move counter.
// Revision    : 1.0 - initial release
// ============================================================================
module elevator_scan_scheduler
    import elevator_pkg::*;
#(
    parameter int FLOOR_W       = c_DEFAULT_FLOOR_W,
    parameter int NUM_FLOORS    = c_DEFAULT_NUM_FLOORS,
    parameter int TRAVEL_CYCLES = c_DEFAULT_TRAVEL_CYCLES,
    parameter int DWELL_CYCLES  = c_DEFAULT_DWELL_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic [FLOOR_W-1:0]    req_floor,
    output logic                  req_ready,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic [FLOOR_W-1:0]    next_floor,
    output logic                  up,
    output logic                  down,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  req_err,
    output logic [15:0]           floor_transition_counter
);

    localparam logic [15:0]           c_TRAVEL_LAST = 16'(TRAVEL_CYCLES - 1);
    localparam logic [15:0]           c_DWELL_LAST  = 16'(DWELL_CYCLES - 1);
    localparam logic [NUM_FLOORS-1:0] c_BIT0        = NUM_FLOORS'(1);

    state_t                r_state, w_state_next;
    dir_t                  r_dir, w_dir_next;
    logic [FLOOR_W-1:0]    r_cur_floor, w_cur_floor_next;
    logic [NUM_FLOORS-1:0] r_pending, w_pending_next;
    logic [15:0]           r_counter, w_counter_next;
    logic [15:0]           r_travel_cnt, w_travel_cnt_next;
    logic [15:0]           r_dwell_cnt, w_dwell_cnt_next;
    logic                  r_ready;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_in_range;
    logic                  w_req_hit;
    logic                  w_req_here;
    logic                  w_at_pending;
    logic [NUM_FLOORS-1:0] w_req_mask;
    logic [NUM_FLOORS-1:0] w_cur_mask;
    logic [NUM_FLOORS-1:0] w_step_mask;
    logic [NUM_FLOORS-1:0] w_set_mask;
    logic [NUM_FLOORS-1:0] w_clr_mask;
    logic [FLOOR_W-1:0]    w_step_floor;
    logic [FLOOR_W-1:0]    w_nearest_ahead;
    logic [15:0]           w_counter_inc;
    logic                  w_ahead_any;
    logic                  w_behind_any;

    scan_target_sel #(
        .FLOOR_W    (FLOOR_W),
        .NUM_FLOORS (NUM_FLOORS)
    ) u_scan_target_sel (
        .pending       (r_pending),
        .current_floor (r_cur_floor),
        .dir           (r_dir),
        .ahead_any     (w_ahead_any),
        .behind_any    (w_behind_any),
        .nearest_ahead (w_nearest_ahead)
    );

    assign w_accept      = req_valid && r_ready;
    assign w_in_range    = 32'(req_floor) < 32'(NUM_FLOORS);
    assign w_req_hit     = w_accept && w_in_range;
    assign w_req_here    = w_req_hit && (req_floor == r_cur_floor);
    assign w_req_mask    = w_req_hit ? (c_BIT0 << req_floor) : '0;
    assign w_cur_mask    = c_BIT0 << r_cur_floor;
    assign w_at_pending  = |(r_pending & w_cur_mask);
    assign w_step_floor  = (r_dir == UP) ? (r_cur_floor + FLOOR_W'(1)) : (r_cur_floor - FLOOR_W'(1));
    assign w_step_mask   = c_BIT0 << w_step_floor;
    assign w_counter_inc = (r_counter != 16'hFFFF) ? (r_counter + 16'd1) : r_counter;

    // Clears win over a same-edge request: a request for the floor being served is absorbed.
    assign w_pending_next = (r_pending | w_set_mask) & ~w_clr_mask;

    always_comb begin
        w_state_next      = r_state;
        w_dir_next        = r_dir;
        w_cur_floor_next  = r_cur_floor;
        w_counter_next    = r_counter;
        w_travel_cnt_next = 16'd0;
        w_dwell_cnt_next  = 16'd0;
        w_set_mask        = w_req_mask;
        w_clr_mask        = '0;
        case (r_state)
            IDLE: begin
                if (w_req_here || w_at_pending) begin
                    w_state_next = DOOR;
                    w_clr_mask   = w_cur_mask;
                end else if (|r_pending) begin
                    if (!w_ahead_any) begin
                        w_dir_next = (r_dir == UP) ? DOWN : UP;
                    end
                    w_state_next = MOVE;
                end
            end
            MOVE: begin
                if (!w_ahead_any) begin
                    w_state_next = IDLE;
                end else if (r_travel_cnt == c_TRAVEL_LAST) begin
                    w_cur_floor_next = w_step_floor;
                    w_counter_next   = w_counter_inc;
                    if (|(r_pending & w_step_mask)) begin
                        w_clr_mask   = w_step_mask;
                        w_state_next = DOOR;
                    end
                end else begin
                    w_travel_cnt_next = r_travel_cnt + 16'd1;
                end
            end
            DOOR: begin
                if (w_req_here) begin
                    w_set_mask = '0;
                end else if (r_dwell_cnt == c_DWELL_LAST) begin
                    if (w_ahead_any) begin
                        w_state_next = MOVE;
                    end else if (w_behind_any) begin
                        w_dir_next   = (r_dir == UP) ? DOWN : UP;
                        w_state_next = MOVE;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else begin
                    w_dwell_cnt_next = r_dwell_cnt + 16'd1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_dir        <= UP;
            r_cur_floor  <= '0;
            r_pending    <= '0;
            r_counter    <= 16'd0;
            r_travel_cnt <= 16'd0;
            r_dwell_cnt  <= 16'd0;
            r_ready      <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_dir        <= w_dir_next;
            r_cur_floor  <= w_cur_floor_next;
            r_pending    <= w_pending_next;
            r_counter    <= w_counter_next;
            r_travel_cnt <= w_travel_cnt_next;
            r_dwell_cnt  <= w_dwell_cnt_next;
            r_ready      <= 1'b1;
            r_err        <= w_accept && !w_in_range;
        end
    end

    assign req_ready                = r_ready;
    assign current_floor            = r_cur_floor;
    assign next_floor               = w_ahead_any ? w_nearest_ahead : r_cur_floor;
    assign up                       = (r_state == MOVE) && (r_dir == UP);
    assign down                     = (r_state == MOVE) && (r_dir == DOWN);
    assign door_open                = (r_state == DOOR);
    assign pending                  = r_pending;
    assign req_err                  = r_err;
    assign floor_transition_counter = r_counter;

endmodule
`default_nettype wire

// File: tb/tb_elevator_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_elevator_scan_scheduler
// Description : Vector table, directed corner cases and random traffic vs. a floor-list model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_elevator_scan_scheduler;

    localparam int FW = 16;
    localparam int NF = 16;
    localparam int TRAVEL = 2;
    localparam int DWELL = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_valid = 1'b0;
    logic [FW-1:0] req_floor = '0;
    logic          req_ready;
    logic [FW-1:0] current_floor;
    logic [FW-1:0] next_floor;
    logic          up;
    logic          down;
    logic          door_open;
    logic [NF-1:0] pending;
    logic          req_err;
    logic [15:0]   floor_transition_counter;

    int checks = 0;
    int failures = 0;

    elevator_scan_scheduler #(
        .FLOOR_W       (FW),
        .NUM_FLOORS    (NF),
        .TRAVEL_CYCLES (TRAVEL),
        .DWELL_CYCLES  (DWELL)
    ) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .req_valid                (req_valid),
        .req_floor                (req_floor),
        .req_ready                (req_ready),
        .current_floor            (current_floor),
        .next_floor               (next_floor),
        .up                       (up),
        .down                     (down),
        .door_open                (door_open),
        .pending                  (pending),
        .req_err                  (req_err),
        .floor_transition_counter (floor_transition_counter)
    );

    always #5 clk = ~clk;

    // Reference model: a list of waiting floors, a signed direction and countdowns.
    int m_floor, m_dir, m_mode, m_left, m_cnt;   // m_mode: 0 idle, 1 moving, 2 door open
    bit m_pend[NF];
    bit m_ready, m_err;

    function automatic int nearest(input int from, input int d);
        for (int s = 1; s < NF; s++) begin
            int f;
            f = from + d * s;
            if (f >= 0 && f < NF && m_pend[f]) return f;
        end
        return -1;
    endfunction

    function automatic bit any_pend();
        for (int k = 0; k < NF; k++) if (m_pend[k]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_floor = 0; m_dir = 1; m_mode = 0; m_left = 0; m_cnt = 0;
        m_ready = 1'b0; m_err = 1'b0;
        for (int k = 0; k < NF; k++) m_pend[k] = 1'b0;
    endtask

    task automatic model_step(input bit v, input int f);
        bit hit, here, keep;
        int clr;
        hit  = v && m_ready && (f < NF);
        here = hit && (f == m_floor);
        keep = hit;
        clr  = -1;
        m_err = v && m_ready && (f >= NF);
        case (m_mode)
            0: begin
                if (here || m_pend[m_floor]) begin
                    clr = m_floor; m_mode = 2; m_left = DWELL;
                end else if (any_pend()) begin
                    if (nearest(m_floor, m_dir) < 0) m_dir = -m_dir;
                    m_mode = 1; m_left = TRAVEL;
                end
            end
            1: begin
                m_left--;
                if (m_left == 0) begin
                    m_floor += m_dir;
                    if (m_cnt < 65535) m_cnt++;
                    if (m_pend[m_floor]) begin
                        clr = m_floor; m_mode = 2; m_left = DWELL;
                    end else begin
                        m_left = TRAVEL;
                    end
                end
            end
            default: begin
                if (here) begin
                    m_left = DWELL; keep = 1'b0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        if (nearest(m_floor, m_dir) >= 0) begin
                            m_mode = 1; m_left = TRAVEL;
                        end else if (nearest(m_floor, -m_dir) >= 0) begin
                            m_dir = -m_dir; m_mode = 1; m_left = TRAVEL;
                        end else begin
                            m_mode = 0;
                        end
                    end
                end
            end
        endcase
        if (keep) m_pend[f] = 1'b1;
        if (clr >= 0) m_pend[clr] = 1'b0;
        m_ready = 1'b1;
    endtask

    function automatic logic [79:0] pk(input logic [15:0] cur, input logic [15:0] nxt,
                                       input logic u, input logic d, input logic dr,
                                       input logic [15:0] pend, input logic er,
                                       input logic [15:0] cnt, input logic rdy);
        return {11'd0, cur, nxt, u, d, dr, pend, er, cnt, rdy};
    endfunction

    function automatic logic [79:0] dut_pack();
        return pk(current_floor, next_floor, up, down, door_open, pending, req_err,
                  floor_transition_counter, req_ready);
    endfunction

    function automatic logic [79:0] model_pack();
        logic [15:0] p;
        int n;
        p = '0;
        for (int k = 0; k < NF; k++) p[k] = m_pend[k];
        n = nearest(m_floor, m_dir);
        if (n < 0) n = m_floor;
        return pk(16'(m_floor), 16'(n), (m_mode == 1) && (m_dir > 0), (m_mode == 1) && (m_dir < 0),
                  m_mode == 2, p, m_err, 16'(m_cnt), m_ready);
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input bit v, input int f);
        req_valid = v;
        req_floor = 16'(f);
        @(posedge clk);
        model_step(v, f);
        #1;
        chk("model", dut_pack(), model_pack());
    endtask

    typedef struct {
        bit v; int f;
        int cur; int nxt; bit u; bit d; bit dr; int pend; bit er; int cnt;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(input bit v, input int f, input int cur, input int nxt,
                                input bit u, input bit d, input bit dr, input int pend,
                                input bit er, input int cnt);
        vec_t r;
        r.v = v; r.f = f; r.cur = cur; r.nxt = nxt; r.u = u; r.d = d; r.dr = dr;
        r.pend = pend; r.er = er; r.cnt = cnt;
        return r;
    endfunction

    initial begin
        int n;
        bit v;
        // Request 5 from reset, full trip, then out-of-range and same-floor requests at 5.
        tbl.push_back(mk(1, 5, 0, 5, 0, 0, 0, 'h20, 0, 0));
        tbl.push_back(mk(0, 0, 0, 5, 1, 0, 0, 'h20, 0, 0));
        tbl.push_back(mk(0, 0, 0, 5, 1, 0, 0, 'h20, 0, 0));
        for (int s = 1; s <= 4; s++) begin
            tbl.push_back(mk(0, 0, s, 5, 1, 0, 0, 'h20, 0, s));
            tbl.push_back(mk(0, 0, s, 5, 1, 0, 0, 'h20, 0, s));
        end
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 5, 5, 0, 0, 1, 0, 0, 5));
        tbl.push_back(mk(0, 0, 5, 5, 0, 0, 0, 0, 0, 5));
        tbl.push_back(mk(1, 20, 5, 5, 0, 0, 0, 0, 1, 5));
        tbl.push_back(mk(0, 0, 5, 5, 0, 0, 0, 0, 0, 5));
        tbl.push_back(mk(1, 5, 5, 5, 0, 0, 1, 0, 0, 5));
        tbl.push_back(mk(0, 0, 5, 5, 0, 0, 1, 0, 0, 5));
        tbl.push_back(mk(0, 0, 5, 5, 0, 0, 1, 0, 0, 5));
        tbl.push_back(mk(0, 0, 5, 5, 0, 0, 0, 0, 0, 5));

        model_reset();
        #1 rst_n = 1'b0;
        #2 chk("reset_outputs", dut_pack(), 80'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        tick(0, 0);

        foreach (tbl[i]) begin
            tick(tbl[i].v, tbl[i].f);
            chk($sformatf("vec%0d", i), dut_pack(),
                pk(16'(tbl[i].cur), 16'(tbl[i].nxt), tbl[i].u, tbl[i].d, tbl[i].dr,
                   16'(tbl[i].pend), tbl[i].er, 16'(tbl[i].cnt), 1'b1));
        end

        // At 5 heading up with requests 7 and 2: serve 7, reverse, serve 2.
        tick(1, 7);
        tick(1, 2);
        for (int i = 0; i < 100 && !door_open; i++) tick(0, 0);
        chk("r041_door7", door_open, 1);
        chk("r041_floor7", current_floor, 7);
        chk("r041_cnt7", floor_transition_counter, 7);
        for (int i = 0; i < 100 && door_open; i++) tick(0, 0);
        chk("r041_reverse", down, 1);
        for (int i = 0; i < 100 && !door_open; i++) tick(0, 0);
        chk("r041_floor2", current_floor, 2);
        chk("r041_cnt12", floor_transition_counter, 12);
        for (int i = 0; i < 100 && door_open; i++) tick(0, 0);

        // Repeat request for 4 while its door is open restarts the dwell.
        tick(1, 4);
        for (int i = 0; i < 100 && !door_open; i++) tick(0, 0);
        chk("r045_floor4", current_floor, 4);
        tick(0, 0);
        tick(1, 4);
        n = 0;
        for (int i = 0; i < 10 && door_open; i++) begin
            n++;
            tick(0, 0);
        end
        chk("r045_dwell", n, 3);
        chk("r045_pending", pending, 0);

        // Asynchronous reset while moving down through floor 3.
        tick(1, 0);
        for (int i = 0; i < 100 && current_floor != 3; i++) tick(0, 0);
        chk("r044_at3_moving", {current_floor, down}, {16'd3, 1'b1});
        rst_n = 1'b0;
        #1 chk("r044_async_zero", dut_pack(), 80'd0);
        repeat (2) @(posedge clk);
        #1 chk("r044_held_zero", dut_pack(), 80'd0);
        rst_n = 1'b1;
        model_reset();
        tick(0, 0);
        chk("r044_idle_floor0", dut_pack(), pk(16'd0, 16'd0, 0, 0, 0, 16'd0, 0, 16'd0, 1));

        // Idle at 0, request 0: door next cycle, bitmap untouched.
        tick(1, 0);
        chk("r043_door", door_open, 1);
        chk("r043_pending", pending, 0);
        chk("r043_cnt", floor_transition_counter, 0);
        for (int i = 0; i < 10 && door_open; i++) tick(0, 0);

        for (int i = 0; i < 3000 && failures < 20; i++) begin
            v = ($urandom_range(0, 3) == 0);
            tick(v, $urandom_range(0, 19));
        end
        for (int i = 0; i < 300 && failures < 20; i++) begin
            tick(1'b1, $urandom_range(0, NF - 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
